// File: rtl/led_chase_game.sv
// LED chase game core: a lit LED sweeps at a level-dependent rate,
// and a synchronised stop button scores a hit on the target LED.
module led_chase_game #(
  parameter int N_LEDS      = 8,
  parameter int BASE_DIV    = 16,
  parameter int DIV_STEP    = 2,
  parameter int MAX_LEVEL   = 7,
  parameter int HOLD_CYCLES = 32,
  parameter int SCORE_W     = 8,
  parameter int IDX_W       = $clog2(N_LEDS),
  parameter int LVL_W       = $clog2(MAX_LEVEL + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   stop_led,
  input  logic               stop_button,
  input  logic               bounce_mode,
  output logic [N_LEDS-1:0]  leds,
  output logic               result_valid,
  output logic               win,
  output logic [SCORE_W-1:0] score,
  output logic [LVL_W-1:0]   level
);

  localparam int CNT_W = $clog2(BASE_DIV + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_LEDS - 1);

  typedef enum logic {RUN, HOLD} state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0]   pos_q, pos_d, nxt_pos;
  logic               dir_q, dir_d, nxt_dir;
  logic [CNT_W-1:0]   cnt_q, cnt_d, last_cnt;
  logic [HLD_W-1:0]   hold_q, hold_d;
  logic               s1_q, s2_q, s3_q;
  logic               v1_q, v2_q;
  logic               armed_q, armed_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               rv_q, rv_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               press, step, hit;
  int                 period;

  always_comb begin
    period = BASE_DIV - int'(level_q) * DIV_STEP;
    if (period < 1) period = 1;
    last_cnt = CNT_W'(period - 1);
  end

  always_comb begin
    nxt_pos = pos_q;
    nxt_dir = dir_q;
    unique case (1'b1)
      !bounce_mode: begin
        nxt_dir = 1'b0;
        nxt_pos = (pos_q == LAST) ? '0 : pos_q + 1'b1;
      end
      bounce_mode && !dir_q: begin
        if (pos_q == LAST) begin
          nxt_pos = IDX_W'(N_LEDS - 2);
          nxt_dir = 1'b1;
        end else begin
          nxt_pos = pos_q + 1'b1;
        end
      end
      default: begin
        if (pos_q == '0) begin
          nxt_pos = IDX_W'(1);
          nxt_dir = 1'b0;
        end else begin
          nxt_pos = pos_q - 1'b1;
        end
      end
    endcase
  end

  // a held button is only armed once a real low sample has been seen
  assign press = armed_q & s2_q & ~s3_q;
  assign step  = (cnt_q == last_cnt);
  assign hit   = (stop_led == pos_q) && (int'(stop_led) < N_LEDS);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    win_d   = win_q;
    score_d = score_q;
    level_d = level_q;
    armed_d = armed_q | (v2_q & ~s2_q);
    unique case (state_q)
      RUN: begin
        if (press) begin
          state_d = HOLD;
          cnt_d   = '0;
          hold_d  = '0;
          win_d   = hit;
          if (hit) begin
            if (score_q != '1) score_d = score_q + 1'b1;
            if (level_q != LVL_W'(MAX_LEVEL)) level_d = level_q + 1'b1;
          end else begin
            level_d = '0;
          end
        end else if (step) begin
          cnt_d = '0;
          pos_d = nxt_pos;
          dir_d = nxt_dir;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == HLD_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    leds_d        = '0;
    leds_d[pos_d] = 1'b1;
    rv_d          = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
      leds_q  <= N_LEDS'(1);
      rv_q    <= 1'b0;
      win_q   <= 1'b0;
      score_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      s1_q    <= stop_button;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      armed_q <= armed_d;
      leds_q  <= leds_d;
      rv_q    <= rv_d;
      win_q   <= win_d;
      score_q <= score_d;
      level_q <= level_d;
    end
  end

  assign leds         = leds_q;
  assign result_valid = rv_q;
  assign win          = win_q;
  assign score        = score_q;
  assign level        = level_q;

endmodule

// File: tb/tb_led_chase_game.sv
// Directed bench for led_chase_game: N=8, BASE_DIV=4, DIV_STEP=1,
// HOLD_CYCLES=5, SCORE_W=3 so saturation is reachable quickly.
module tb_led_chase_game;

  logic       clk;
  logic       reset;
  logic [2:0] stop_led;
  logic       stop_button;
  logic       bounce_mode;
  logic [7:0] leds;
  logic       result_valid;
  logic       win;
  logic [2:0] score;
  logic [2:0] level;

  int n_assert;
  int n_fail;
  int exp_score;
  int exp_level;

  led_chase_game #(
    .N_LEDS(8), .BASE_DIV(4), .DIV_STEP(1), .MAX_LEVEL(7),
    .HOLD_CYCLES(5), .SCORE_W(3)
  ) dut (
    .clk(clk), .reset(reset), .stop_led(stop_led),
    .stop_button(stop_button), .bounce_mode(bounce_mode),
    .leds(leds), .result_valid(result_valid), .win(win),
    .score(score), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // wait for the lit LED to move onto LED0 (bounded)
  task automatic wait_pos0(output logic ok);
    int k;
    logic ok1;
    k = 0;
    while (leds == 8'h01 && k < 60) begin tick(1); k++; end
    ok1 = (leds != 8'h01);
    k = 0;
    while (leds != 8'h01 && k < 60) begin tick(1); k++; end
    ok = ok1 && (leds == 8'h01);
  endtask

  task automatic do_win;
    int p;
    logic ok;
    p = 4 - exp_level;
    if (p < 1) p = 1;
    wait_pos0(ok);
    chk("win_wait", 32'(ok), 32'd1);
    stop_led = (p >= 3) ? 3'd0 : 3'(3 - p);
    stop_button = 1'b1;
    tick(3);
    if (exp_score < 7) exp_score++;
    if (exp_level < 7) exp_level++;
    chk("sat_win", 32'(win), 32'd1);
    chk("sat_score", 32'(score), 32'(exp_score));
    chk("sat_level", 32'(level), 32'(exp_level));
    stop_button = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [7:0] pp [15];
    logic ok;
    n_assert = 0;
    n_fail = 0;
    pp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    reset = 1'b0;
    stop_led = 3'd3;
    stop_button = 1'b0;
    bounce_mode = 1'b0;
    #12;
    chk("rst_leds", 32'(leds), 32'h01);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // ring mode, period 4
    tick(3);
    chk("ring_hold0", 32'(leds), 32'h01);
    tick(1);
    chk("ring_step1", 32'(leds), 32'h02);
    for (int i = 2; i <= 8; i++) begin
      tick(3);
      chk("ring_still", 32'(leds), 32'(1 << ((i - 1) % 8)));
      tick(1);
      chk("ring_step", 32'(leds), 32'(1 << (i % 8)));
    end
    chk("ring_score", 32'(score), 32'd0);
    chk("ring_level", 32'(level), 32'd0);

    // ping-pong from LED0 going up
    bounce_mode = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(4);
      chk("pp_step", 32'(leds), 32'(pp[i]));
    end
    bounce_mode = 1'b0;

    // pos=1 just stepped; press so pos 3 is compared
    tick(6);
    stop_button = 1'b1;
    tick(2);
    chk("lat_rv_low", 32'(result_valid), 32'd0);
    tick(1);
    chk("w1_rv", 32'(result_valid), 32'd1);
    chk("w1_win", 32'(win), 32'd1);
    chk("w1_score", 32'(score), 32'd1);
    chk("w1_level", 32'(level), 32'd1);
    chk("w1_leds", 32'(leds), 32'h08);
    tick(4);
    chk("w1_hold_rv", 32'(result_valid), 32'd1);
    chk("w1_frozen", 32'(leds), 32'h08);
    tick(1);
    chk("w1_rv_end", 32'(result_valid), 32'd0);
    tick(2);
    chk("w1_p3_still", 32'(leds), 32'h08);
    tick(1);
    chk("w1_p3_step", 32'(leds), 32'h10);

    // press evaluated on a step-boundary cycle at pos 6
    stop_button = 1'b0;
    tick(6);
    stop_led = 3'd6;
    stop_button = 1'b1;
    tick(3);
    chk("bnd_win", 32'(win), 32'd1);
    chk("bnd_score", 32'(score), 32'd2);
    chk("bnd_level", 32'(level), 32'd2);
    chk("bnd_leds", 32'(leds), 32'h40);
    chk("bnd_rv", 32'(result_valid), 32'd1);

    // glitch during HOLD, then button held
    stop_button = 1'b0;
    tick(1);
    stop_button = 1'b1;
    tick(3);
    chk("gl_rv", 32'(result_valid), 32'd1);
    chk("gl_leds", 32'(leds), 32'h40);
    tick(1);
    chk("gl_rv_end", 32'(result_valid), 32'd0);
    chk("gl_score", 32'(score), 32'd2);
    tick(2);
    chk("gl_p2_step", 32'(leds), 32'h80);
    tick(60);
    chk("held_rv", 32'(result_valid), 32'd0);
    chk("held_score", 32'(score), 32'd2);

    // loss on a wrong LED
    stop_button = 1'b0;
    tick(3);
    stop_led = 3'd5;
    wait_pos0(ok);
    chk("loss_wait", 32'(ok), 32'd1);
    stop_button = 1'b1;
    tick(3);
    chk("loss_rv", 32'(result_valid), 32'd1);
    chk("loss_win", 32'(win), 32'd0);
    chk("loss_level", 32'(level), 32'd0);
    chk("loss_score", 32'(score), 32'd2);

    // async reset mid-HOLD with button held
    #2 reset = 1'b0;
    #1;
    chk("ar_leds", 32'(leds), 32'h01);
    chk("ar_rv", 32'(result_valid), 32'd0);
    chk("ar_score", 32'(score), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_win", 32'(win), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(10);
    chk("ar_nopress_rv", 32'(result_valid), 32'd0);
    chk("ar_nopress_sc", 32'(score), 32'd0);
    stop_button = 1'b0;
    tick(3);

    // repeated wins: score and level saturate at 7
    exp_score = 0;
    exp_level = 0;
    for (int k = 0; k < 8; k++) do_win();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
